// File: rtl/ysyx_exu_csr_seq_if.sv
// Bundled ports of the EXU CSR sequencer: the op input channel, the CSR file port and the result channel.
// master = sequencer side, slave = producer / CSR file / consumer side.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

interface ysyx_exu_csr_seq_if #(
    parameter int BIT_W = `YSYX_W_WIDTH,
    parameter int R_W   = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic             in_ecall;
    logic             in_mret;
    logic [R_W-1:0]   in_csr_addr;
    logic [4:0]       in_rs1_idx;
    logic [BIT_W-1:0] in_rs1_data;
    logic [BIT_W-1:0] in_pc;

    logic [BIT_W-1:0] csr_rdata;
    logic [BIT_W-1:0] csr_mtvec;
    logic [BIT_W-1:0] csr_mepc;
    logic [R_W-1:0]   csr_waddr0;
    logic [R_W-1:0]   csr_waddr1;
    logic [BIT_W-1:0] csr_wdata0;
    logic [BIT_W-1:0] csr_wdata1;
    logic             csr_wen;
    logic             csr_exu_valid;
    logic             csr_ecallen;

    logic             out_valid;
    logic             out_ready;
    logic [BIT_W-1:0] out_rd_data;
    logic             out_redirect;
    logic [BIT_W-1:0] out_npc;
    logic             out_illegal;

    modport master (
        input  in_valid, in_funct3, in_ecall, in_mret, in_csr_addr, in_rs1_idx, in_rs1_data, in_pc,
        output in_ready,
        input  csr_rdata, csr_mtvec, csr_mepc,
        output csr_waddr0, csr_waddr1, csr_wdata0, csr_wdata1, csr_wen, csr_exu_valid, csr_ecallen,
        output out_valid, out_rd_data, out_redirect, out_npc, out_illegal,
        input  out_ready
    );

    modport slave (
        output in_valid, in_funct3, in_ecall, in_mret, in_csr_addr, in_rs1_idx, in_rs1_data, in_pc,
        input  in_ready,
        output csr_rdata, csr_mtvec, csr_mepc,
        input  csr_waddr0, csr_waddr1, csr_wdata0, csr_wdata1, csr_wen, csr_exu_valid, csr_ecallen,
        input  out_valid, out_rd_data, out_redirect, out_npc, out_illegal,
        output out_ready
    );
endinterface

// File: rtl/ysyx_exu_csr_seq.sv
// EXU CSR access sequencer: IDLE -> RD -> WR -> RESP per CSR/ECALL/MRET op, all outputs registered.
// Optional macro YSYX_CSR_RO_CHECK_EN suppresses writes to read-only CSRs (addr[11:10]==2'b11) and flags out_illegal.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_exu_csr_seq #(
    parameter int BIT_W = `YSYX_W_WIDTH,
    parameter int R_W   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    ysyx_exu_csr_seq_if.master  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_e;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             ecall_q, ecall_d;
    logic             mret_q, mret_d;
    logic [R_W-1:0]   addr_q, addr_d;
    logic [4:0]       rs1_idx_q, rs1_idx_d;
    logic [BIT_W-1:0] rs1_data_q, rs1_data_d;
    logic [BIT_W-1:0] pc_q, pc_d;
    logic [BIT_W-1:0] rd_q, rd_d;
    logic             illegal_q, illegal_d;
    logic [R_W-1:0]   waddr0_q, waddr0_d;
    logic [R_W-1:0]   waddr1_q, waddr1_d;
    logic [BIT_W-1:0] wdata0_q, wdata0_d;
    logic [BIT_W-1:0] wdata1_q, wdata1_d;
    logic             wen_q, wen_d;
    logic             exu_valid_q, exu_valid_d;
    logic             ecallen_q, ecallen_d;
    logic             out_valid_q, out_valid_d;
    logic [BIT_W-1:0] out_rd_q, out_rd_d;
    logic             out_redirect_q, out_redirect_d;
    logic [BIT_W-1:0] out_npc_q, out_npc_d;
    logic             out_illegal_q, out_illegal_d;

    logic [BIT_W-1:0] src_s;
    logic [BIT_W-1:0] new_s;
    logic             wr_s;
    logic             ro_s;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_d        = state_q;
        in_ready_d     = in_ready_q;
        funct3_d       = funct3_q;
        ecall_d        = ecall_q;
        mret_d         = mret_q;
        addr_d         = addr_q;
        rs1_idx_d      = rs1_idx_q;
        rs1_data_d     = rs1_data_q;
        pc_d           = pc_q;
        rd_d           = rd_q;
        illegal_d      = illegal_q;
        waddr0_d       = waddr0_q;
        waddr1_d       = waddr1_q;
        wdata0_d       = wdata0_q;
        wdata1_d       = wdata1_q;
        wen_d          = 1'b0;
        exu_valid_d    = 1'b0;
        ecallen_d      = 1'b0;
        out_valid_d    = out_valid_q;
        out_rd_d       = out_rd_q;
        out_redirect_d = out_redirect_q;
        out_npc_d      = out_npc_q;
        out_illegal_d  = out_illegal_q;

        src_s = funct3_q[2] ? {{(BIT_W-5){1'b0}}, rs1_idx_q} : rs1_data_q;
        case (funct3_q[1:0])
            2'b01: begin
                new_s = src_s;
                wr_s  = 1'b1;
            end
            2'b10: begin
                new_s = bus.csr_rdata | src_s;
                wr_s  = (rs1_idx_q != 5'd0);
            end
            2'b11: begin
                new_s = bus.csr_rdata & ~src_s;
                wr_s  = (rs1_idx_q != 5'd0);
            end
            default: begin
                new_s = bus.csr_rdata;
                wr_s  = 1'b0;
            end
        endcase
`ifdef YSYX_CSR_RO_CHECK_EN
        ro_s = wr_s && (addr_q[R_W-1:R_W-2] == 2'b11);
`else
        ro_s = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d    = RD;
                    in_ready_d = 1'b0;
                    funct3_d   = bus.in_funct3;
                    ecall_d    = bus.in_ecall;
                    mret_d     = bus.in_mret && !bus.in_ecall;
                    addr_d     = bus.in_csr_addr;
                    rs1_idx_d  = bus.in_rs1_idx;
                    rs1_data_d = bus.in_rs1_data;
                    pc_d       = bus.in_pc;
                    waddr0_d   = bus.in_csr_addr;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (flush) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end else if (ecall_q) begin
                    state_d     = WR;
                    rd_d        = {BIT_W{1'b0}};
                    illegal_d   = 1'b0;
                    wen_d       = 1'b1;
                    exu_valid_d = 1'b1;
                    ecallen_d   = 1'b1;
                    waddr0_d    = R_W'(12'h341);
                    wdata0_d    = pc_q;
                    waddr1_d    = R_W'(12'h342);
                    wdata1_d    = BIT_W'(32'd11);
                end else if (mret_q) begin
                    state_d   = WR;
                    rd_d      = {BIT_W{1'b0}};
                    illegal_d = 1'b0;
                end else begin
                    state_d   = WR;
                    rd_d      = bus.csr_rdata;
                    illegal_d = ro_s;
                    if (wr_s && !ro_s) begin
                        wen_d       = 1'b1;
                        exu_valid_d = 1'b1;
                        waddr0_d    = addr_q;
                        wdata0_d    = new_s;
                        waddr1_d    = addr_q;
                        wdata1_d    = new_s;
                    end else begin
                        waddr0_d = addr_q;
                    end
                end
            end
            WR: begin
                // Committed: flush no longer has any effect from here on.
                state_d        = RESP;
                out_valid_d    = 1'b1;
                out_rd_d       = rd_q;
                out_redirect_d = ecall_q || mret_q;
                out_npc_d      = ecall_q ? bus.csr_mtvec : (mret_q ? bus.csr_mepc : {BIT_W{1'b0}});
                out_illegal_d  = illegal_q;
                waddr0_d       = addr_q;
                waddr1_d       = {R_W{1'b0}};
                wdata0_d       = {BIT_W{1'b0}};
                wdata1_d       = {BIT_W{1'b0}};
            end
            RESP: begin
                if (bus.out_ready) begin
                    state_d        = IDLE;
                    in_ready_d     = 1'b1;
                    out_valid_d    = 1'b0;
                    out_rd_d       = {BIT_W{1'b0}};
                    out_redirect_d = 1'b0;
                    out_npc_d      = {BIT_W{1'b0}};
                    out_illegal_d  = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered-output flops; async active-low reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b0;
            funct3_q       <= 3'd0;
            ecall_q        <= 1'b0;
            mret_q         <= 1'b0;
            addr_q         <= {R_W{1'b0}};
            rs1_idx_q      <= 5'd0;
            rs1_data_q     <= {BIT_W{1'b0}};
            pc_q           <= {BIT_W{1'b0}};
            rd_q           <= {BIT_W{1'b0}};
            illegal_q      <= 1'b0;
            waddr0_q       <= {R_W{1'b0}};
            waddr1_q       <= {R_W{1'b0}};
            wdata0_q       <= {BIT_W{1'b0}};
            wdata1_q       <= {BIT_W{1'b0}};
            wen_q          <= 1'b0;
            exu_valid_q    <= 1'b0;
            ecallen_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_rd_q       <= {BIT_W{1'b0}};
            out_redirect_q <= 1'b0;
            out_npc_q      <= {BIT_W{1'b0}};
            out_illegal_q  <= 1'b0;
        end else begin
            // in_ready comes up on the first edge after reset release, since it flops the IDLE status.
            state_q        <= state_d;
            in_ready_q     <= (state_d == IDLE);
            funct3_q       <= funct3_d;
            ecall_q        <= ecall_d;
            mret_q         <= mret_d;
            addr_q         <= addr_d;
            rs1_idx_q      <= rs1_idx_d;
            rs1_data_q     <= rs1_data_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            illegal_q      <= illegal_d;
            waddr0_q       <= waddr0_d;
            waddr1_q       <= waddr1_d;
            wdata0_q       <= wdata0_d;
            wdata1_q       <= wdata1_d;
            wen_q          <= wen_d;
            exu_valid_q    <= exu_valid_d;
            ecallen_q      <= ecallen_d;
            out_valid_q    <= out_valid_d;
            out_rd_q       <= out_rd_d;
            out_redirect_q <= out_redirect_d;
            out_npc_q      <= out_npc_d;
            out_illegal_q  <= out_illegal_d;
        end
    end

    logic unused_in_ready_d;
    assign unused_in_ready_d = in_ready_d;

    assign bus.in_ready      = in_ready_q;
    assign bus.csr_waddr0    = waddr0_q;
    assign bus.csr_waddr1    = waddr1_q;
    assign bus.csr_wdata0    = wdata0_q;
    assign bus.csr_wdata1    = wdata1_q;
    assign bus.csr_wen       = wen_q;
    assign bus.csr_exu_valid = exu_valid_q;
    assign bus.csr_ecallen   = ecallen_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_rd_data   = out_rd_q;
    assign bus.out_redirect  = out_redirect_q;
    assign bus.out_npc       = out_npc_q;
    assign bus.out_illegal   = out_illegal_q;
endmodule

// File: tb/tb_ysyx_exu_csr_seq.sv
// Table-driven bench for ysyx_exu_csr_seq plus hand-written stall, flush and reset sequences.
module tb_ysyx_exu_csr_seq;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ysyx_exu_csr_seq_if #(.BIT_W(32), .R_W(12)) bus ();

    ysyx_exu_csr_seq #(.BIT_W(32), .R_W(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        ecall;
        logic        mret;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] old;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        e_wen;
        logic        e_ecallen;
        logic [11:0] e_wa0;
        logic [31:0] e_wd0;
        logic [11:0] e_wa1;
        logic [31:0] e_wd1;
        logic [31:0] e_rd;
        logic        e_redir;
        logic [31:0] e_npc;
        logic        e_ill;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        bus.in_valid    = 1'b1;
        bus.in_funct3   = vecs[i].f3;
        bus.in_ecall    = vecs[i].ecall;
        bus.in_mret     = vecs[i].mret;
        bus.in_csr_addr = vecs[i].addr;
        bus.in_rs1_idx  = vecs[i].idx;
        bus.in_rs1_data = vecs[i].data;
        bus.in_pc       = vecs[i].pc;
        bus.csr_rdata   = vecs[i].old;
        bus.csr_mtvec   = vecs[i].mtvec;
        bus.csr_mepc    = vecs[i].mepc;
    endtask

    task automatic check_wr(input int i);
        chk("wen", {31'd0, bus.csr_wen}, {31'd0, vecs[i].e_wen});
        chk("exu_valid", {31'd0, bus.csr_exu_valid}, {31'd0, vecs[i].e_wen});
        chk("ecallen", {31'd0, bus.csr_ecallen}, {31'd0, vecs[i].e_ecallen});
        if (vecs[i].e_wen) begin
            chk("waddr0", {20'd0, bus.csr_waddr0}, {20'd0, vecs[i].e_wa0});
            chk("wdata0", bus.csr_wdata0, vecs[i].e_wd0);
            chk("waddr1", {20'd0, bus.csr_waddr1}, {20'd0, vecs[i].e_wa1});
            chk("wdata1", bus.csr_wdata1, vecs[i].e_wd1);
        end
    endtask

    task automatic check_resp(input int i);
        chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("rd_data", bus.out_rd_data, vecs[i].e_rd);
        chk("redirect", {31'd0, bus.out_redirect}, {31'd0, vecs[i].e_redir});
        chk("npc", bus.out_npc, vecs[i].e_npc);
        chk("illegal", {31'd0, bus.out_illegal}, {31'd0, vecs[i].e_ill});
        chk("resp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("resp_wen", {31'd0, bus.csr_wen}, 32'd0);
    endtask

    initial begin
        //          f3    ec    mr    addr     idx   data           pc             old            mtvec          mepc           wen  ecal wa0      wd0            wa1      wd1            rd             redir npc           ill
        vecs[0]  = '{3'b001, 1'b0, 1'b0, 12'h305, 5'd1,  32'h8000_0100, 32'h0,         32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 12'h305, 32'h8000_0100, 12'h305, 32'h8000_0100, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[1]  = '{3'b010, 1'b0, 1'b0, 12'h300, 5'd5,  32'h8,         32'h0,         32'h1800,      32'h0,         32'h0,         1'b1, 1'b0, 12'h300, 32'h1808,      12'h300, 32'h1808,      32'h1800,      1'b0, 32'h0,         1'b0};
        vecs[2]  = '{3'b010, 1'b0, 1'b0, 12'h300, 5'd0,  32'h8,         32'h0,         32'h1800,      32'h0,         32'h0,         1'b0, 1'b0, 12'h0,   32'h0,         12'h0,   32'h0,         32'h1800,      1'b0, 32'h0,         1'b0};
        vecs[3]  = '{3'b111, 1'b0, 1'b0, 12'h341, 5'd3,  32'hFFFF_FFFF, 32'h0,         32'h8000_0007, 32'h0,         32'h0,         1'b1, 1'b0, 12'h341, 32'h8000_0004, 12'h341, 32'h8000_0004, 32'h8000_0007, 1'b0, 32'h0,         1'b0};
        vecs[4]  = '{3'b001, 1'b1, 1'b0, 12'h305, 5'd1,  32'h1111,      32'h8000_0040, 32'h55,        32'h8000_0200, 32'h0,         1'b1, 1'b1, 12'h341, 32'h8000_0040, 12'h342, 32'd11,        32'h0,         1'b1, 32'h8000_0200, 1'b0};
        vecs[5]  = '{3'b000, 1'b0, 1'b1, 12'h341, 5'd0,  32'h0,         32'h0,         32'h77,        32'h8000_0200, 32'h8000_0044, 1'b0, 1'b0, 12'h0,   32'h0,         12'h0,   32'h0,         32'h0,         1'b1, 32'h8000_0044, 1'b0};
        vecs[6]  = '{3'b000, 1'b1, 1'b1, 12'h300, 5'd0,  32'h0,         32'h8000_0010, 32'h99,        32'h8000_0300, 32'h8000_0999, 1'b1, 1'b1, 12'h341, 32'h8000_0010, 12'h342, 32'd11,        32'h0,         1'b1, 32'h8000_0300, 1'b0};
        vecs[7]  = '{3'b101, 1'b0, 1'b0, 12'h340, 5'd31, 32'hABCD_0000, 32'h0,         32'h1234,      32'h0,         32'h0,         1'b1, 1'b0, 12'h340, 32'h1F,        12'h340, 32'h1F,        32'h1234,      1'b0, 32'h0,         1'b0};
        vecs[8]  = '{3'b101, 1'b0, 1'b0, 12'h340, 5'd0,  32'hABCD_0000, 32'h0,         32'h1234,      32'h0,         32'h0,         1'b1, 1'b0, 12'h340, 32'h0,         12'h340, 32'h0,         32'h1234,      1'b0, 32'h0,         1'b0};
        vecs[9]  = '{3'b110, 1'b0, 1'b0, 12'h300, 5'd4,  32'h0,         32'h0,         32'h1,         32'h0,         32'h0,         1'b1, 1'b0, 12'h300, 32'h5,         12'h300, 32'h5,         32'h1,         1'b0, 32'h0,         1'b0};
        vecs[10] = '{3'b011, 1'b0, 1'b0, 12'h304, 5'd2,  32'hF0,        32'h0,         32'hFF,        32'h0,         32'h0,         1'b1, 1'b0, 12'h304, 32'h0F,        12'h304, 32'h0F,        32'hFF,        1'b0, 32'h0,         1'b0};
`ifdef YSYX_CSR_RO_CHECK_EN
        vecs[11] = '{3'b001, 1'b0, 1'b0, 12'hF11, 5'd1,  32'hDEAD,      32'h0,         32'h100,       32'h0,         32'h0,         1'b0, 1'b0, 12'h0,   32'h0,         12'h0,   32'h0,         32'h100,       1'b0, 32'h0,         1'b1};
`else
        vecs[11] = '{3'b001, 1'b0, 1'b0, 12'hF11, 5'd1,  32'hDEAD,      32'h0,         32'h100,       32'h0,         32'h0,         1'b1, 1'b0, 12'hF11, 32'hDEAD,      12'hF11, 32'hDEAD,      32'h100,       1'b0, 32'h0,         1'b0};
`endif

        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_funct3 = 3'd0; bus.in_ecall = 1'b0; bus.in_mret = 1'b0;
        bus.in_csr_addr = 12'd0; bus.in_rs1_idx = 5'd0; bus.in_rs1_data = 32'd0; bus.in_pc = 32'd0;
        bus.csr_rdata = 32'd0; bus.csr_mtvec = 32'd0; bus.csr_mepc = 32'd0; bus.out_ready = 1'b1;

        step(); step();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_wen", {31'd0, bus.csr_wen}, 32'd0);
        chk("rst_npc", bus.out_npc, 32'd0);
        #3 rst = 1'b1;
        step(); step();
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Main table: accept (cycle 0), RD (1), WR strobe (2), RESP (3), back to IDLE.
        for (int i = 0; i < 12; i++) begin
            drive(i);
            chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
            step();
            bus.in_valid = 1'b0;
            chk("rd_waddr0", {20'd0, bus.csr_waddr0}, {20'd0, vecs[i].addr});
            chk("rd_wen", {31'd0, bus.csr_wen}, 32'd0);
            step();
            check_wr(i);
            step();
            check_resp(i);
            step();
            chk("done_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("done_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end

        // Stall: out_ready low for 5 cycles holds RESP stable; flush in WR is ignored.
        bus.out_ready = 1'b0;
        drive(1);
        step();
        bus.in_valid = 1'b0;
        step();
        flush = 1'b1;
        check_wr(1);
        step();
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_resp(1);
            step();
        end
        bus.out_ready = 1'b1;
        check_resp(1);
        step();
        chk("stall_done_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("stall_done_ready", {31'd0, bus.in_ready}, 32'd1);

        // Flush in RD: no strobe and no result.
        drive(0);
        step();
        bus.in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_wen", {31'd0, bus.csr_wen}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("flush_no_wen", {31'd0, bus.csr_wen}, 32'd0);
            step();
        end

        // Reset asserted while the write strobe is high cuts it at once.
        drive(0);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("wr_wen_before_rst", {31'd0, bus.csr_wen}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_cut_wen", {31'd0, bus.csr_wen}, 32'd0);
        chk("rst_cut_exu_valid", {31'd0, bus.csr_exu_valid}, 32'd0);
        chk("rst_cut_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_cut_waddr0", {20'd0, bus.csr_waddr0}, 32'd0);
        step();
        #2 rst = 1'b1;
        step(); step();
        chk("rst_cut_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_recover_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
